// File: rtl/logic_gate_pkg.sv
// Shared definitions for the registered bitwise logic unit: opcode
// encodings and the legal parameter ranges.
package logic_gate_pkg;

    // Opcode encodings for in_op / out_op
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_BUF  = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    // Legal parameter ranges
    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 32;
    localparam int MIN_NIN   = 2;
    localparam int MAX_NIN   = 8;

endpackage

// File: rtl/logic_gate_pipe_gate_slice.sv
// One bit position of the gate network: reduces NIN operand bits with
// built-in gate primitives and selects the result named by the opcode.
module gate_slice
    import logic_gate_pkg::*;
#(
    parameter int NIN = 2
) (
    input  logic [NIN-1:0] in_bits,
    input  logic [2:0]     op,
    output logic           y
);

    // Unused primitive inputs are tied to the identity element of each
    // gate (1 for and/nand, 0 for or/nor/xor/xnor), so one fixed-width
    // instance per gate type computes the NIN-operand reduction exactly.
    logic [MAX_NIN-1:0] one_pad;
    logic [MAX_NIN-1:0] zero_pad;

    wire y_and;
    wire y_nand;
    wire y_or;
    wire y_nor;
    wire y_xor;
    wire y_xnor;
    wire y_buf;
    wire y_not;

    // Pad the live operand bits out to the fixed primitive width
    always_comb begin
        one_pad            = '1;
        zero_pad           = '0;
        one_pad[NIN-1:0]   = in_bits;
        zero_pad[NIN-1:0]  = in_bits;
    end

    and  u_and  (y_and,  one_pad[0],  one_pad[1],  one_pad[2],  one_pad[3],
                         one_pad[4],  one_pad[5],  one_pad[6],  one_pad[7]);
    nand u_nand (y_nand, one_pad[0],  one_pad[1],  one_pad[2],  one_pad[3],
                         one_pad[4],  one_pad[5],  one_pad[6],  one_pad[7]);
    or   u_or   (y_or,   zero_pad[0], zero_pad[1], zero_pad[2], zero_pad[3],
                         zero_pad[4], zero_pad[5], zero_pad[6], zero_pad[7]);
    nor  u_nor  (y_nor,  zero_pad[0], zero_pad[1], zero_pad[2], zero_pad[3],
                         zero_pad[4], zero_pad[5], zero_pad[6], zero_pad[7]);
    xor  u_xor  (y_xor,  zero_pad[0], zero_pad[1], zero_pad[2], zero_pad[3],
                         zero_pad[4], zero_pad[5], zero_pad[6], zero_pad[7]);
    xnor u_xnor (y_xnor, zero_pad[0], zero_pad[1], zero_pad[2], zero_pad[3],
                         zero_pad[4], zero_pad[5], zero_pad[6], zero_pad[7]);
    buf  u_buf  (y_buf,  in_bits[0]);
    not  u_not  (y_not,  in_bits[0]);

    // Select the gate output named by the opcode
    always_comb begin
        y = 1'b0;
        case (op)
            OP_AND:  y = y_and;
            OP_NAND: y = y_nand;
            OP_OR:   y = y_or;
            OP_NOR:  y = y_nor;
            OP_XOR:  y = y_xor;
            OP_XNOR: y = y_xnor;
            OP_BUF:  y = y_buf;
            OP_NOT:  y = y_not;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage registered bitwise logic unit. S1 captures operands and
// opcode, S2 captures the gate-network result and drives the outputs.
// Handshake: a beat moves on any cycle where valid && ready are both high;
// ready is computed combinationally back through the stages so a full
// pipeline still accepts a beat in the same cycle the output is taken.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NIN   = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [2:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           out_op,
    output logic [CNT_W-1:0]     done_cnt
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || NIN < MIN_NIN || NIN > MAX_NIN) begin : g_param_check
        $error("logic_gate_pipe: WIDTH or NIN outside the supported range");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                 s1_valid_q, s1_valid_d;
    logic [NIN*WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [2:0]           s1_op_q,    s1_op_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]     s2_data_q,  s2_data_d;
    logic [2:0]           s2_op_q,    s2_op_d;
    logic [CNT_W-1:0]     done_cnt_q, done_cnt_d;

    logic                 s1_ready;
    logic                 s2_ready;
    logic                 s1_load;
    logic                 s2_load;
    logic [WIDTH-1:0]     net_result;

    // Gate network: one slice per bit position, fed from the S1 registers
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [NIN-1:0] slice_bits;

        // Gather bit i of every operand
        always_comb begin
            slice_bits = '0;
            for (int k = 0; k < NIN; k++) begin
                slice_bits[k] = s1_data_q[k*WIDTH + i];
            end
        end

        gate_slice #(.NIN(NIN)) u_slice (
            .in_bits (slice_bits),
            .op      (s1_op_q),
            .y       (net_result[i])
        );
    end

    // Ready chain, stage loads and next-state values
    always_comb begin
        s2_ready   = !s2_valid_q || out_ready;
        s1_ready   = !s1_valid_q || s2_ready;
        s1_load    = in_valid && s1_ready;
        s2_load    = s1_valid_q && s2_ready;

        s1_valid_d = s1_load || (s1_valid_q && !s2_ready);
        s1_data_d  = s1_data_q;
        s1_op_d    = s1_op_q;
        if (s1_load) begin
            s1_data_d = in_data;
            s1_op_d   = in_op;
        end

        s2_valid_d = s2_load || (s2_valid_q && !out_ready);
        s2_data_d  = s2_data_q;
        s2_op_d    = s2_op_q;
        if (s2_load) begin
            s2_data_d = net_result;
            s2_op_d   = s1_op_q;
        end

        done_cnt_d = done_cnt_q;
        if (s2_valid_q && out_ready && (done_cnt_q != {CNT_W{1'b1}})) begin
            done_cnt_d = done_cnt_q + CNT_ONE;
        end
    end

    // Pipeline and counter registers; reset discards every in-flight beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_op_q    <= '0;
            done_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_op_q    <= s2_op_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign in_ready  = s1_ready;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_op    = s2_op_q;
    assign done_cnt  = done_cnt_q;

endmodule
